fetch_stage_pipelined: RTL

Parametrised instruction fetch stage with an IF/ID pipeline register. Generates the instruction-memory address and resolves direct jumps in fetch with no bubble. Supports decode stall, redirect/flush from later stages, halt detection and a saturating fetch counter. Sits between the instruction memory and the decode stage of the pipelined processor.

---
 rtl/fetch_stage_pipelined.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_stage_pipelined.sv
// Instruction fetch stage with IF/ID register: direct jumps resolved in fetch,
// decode stall, later-stage redirect/flush, halt detection and a saturating fetch counter.
module fetch_stage_pipelined #(
  parameter int                 ADDR_W       = 8,
  parameter int                 INSTR_W      = 8,
  parameter int                 JUMP_FIELD_W = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE  = {INSTR_W{1'b1}},
  parameter int                 COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic               ifid_valid_reg, ifid_valid_next;
  logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
  logic [ADDR_W-1:0]  ifid_pc_reg, ifid_pc_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  jump_target;
  logic               is_halt;
  logic               is_jump;

  assign pc_plus1    = pc_reg + ADDR_W'(1);
  // Jump keeps the upper bits of the sequential PC and replaces the low field.
  assign jump_target = {pc_plus1[ADDR_W-1:JUMP_FIELD_W], imem_rdata[JUMP_FIELD_W-1:0]};
  assign is_halt     = (imem_rdata == HALT_OPCODE);
  assign is_jump     = imem_rdata[INSTR_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= '0;
      ifid_pc_reg    <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_valid_reg <= ifid_valid_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc_reg    <= ifid_pc_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_valid_next = ifid_valid_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc_next    = ifid_pc_reg;
    count_next      = count_reg;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
        if (redirect_valid) pc_next = redirect_target;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_next         = redirect_target;
          ifid_valid_next = 1'b0;
        end else if (!stall) begin
          ifid_instr_next = imem_rdata;
          ifid_pc_next    = pc_reg;
          ifid_valid_next = 1'b1;
          count_next      = (count_reg == '1) ? count_reg : count_reg + COUNT_W'(1);
          // Halt wins over the jump flag; PC stays on the halt instruction.
          if (is_halt)      state_next = HALTED;
          else if (is_jump) pc_next    = jump_target;
          else              pc_next    = pc_plus1;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          state_next      = RUN;
          pc_next         = redirect_target;
          ifid_valid_next = 1'b0;
        end else if (!stall) begin
          ifid_valid_next = 1'b0;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem_addr   = pc_reg;
  assign ifid_valid  = ifid_valid_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_pc     = ifid_pc_reg;
  assign fetch_count = count_reg;
  assign halted      = (state_reg == HALTED);

endmodule
